// File: rtl/bic_pkg.sv
// bic_pkg: shared types and frame-length helper for the bit-in-character framer.
`default_nettype none

package bic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bic_state_t;

    typedef struct packed {
        logic [1:0] data_bits;
        logic       parity_en;
        logic       stop_bits;
    } bic_cfg_t;

    localparam int MAX_FRAME_LEN = 12;

    // start + (5..8 data) + optional parity + (1..2 stop): 7..12 bits
    function automatic logic [3:0] frame_len(bic_cfg_t c);
        return 4'd7 + {2'b00, c.data_bits} + {3'b000, c.parity_en} + {3'b000, c.stop_bits};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bic_tick_counter.sv
// bic_tick_counter: OVERSAMPLE-modulo tick counter with mid-bit and wrap decodes.
`default_nettype none

module bic_tick_counter
    import bic_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
    input  logic sr_clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic mid,
    output logic wrap
);

    localparam logic [TICK_W-1:0] c_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    always_ff @(posedge sr_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    always_comb begin
        tick_d = tick_q;
        if (clear) begin
            tick_d = '0;
        end else if (enable) begin
            tick_d = (tick_q == c_TICK_LAST) ? '0 : tick_q + 1'b1;
        end
    end

    // Decodes look only at registered count and enable, never at clear
    assign mid  = enable & (tick_q == c_TICK_MID);
    assign wrap = enable & (tick_q == c_TICK_LAST);

endmodule

`default_nettype wire

// File: rtl/bic_frame.sv
// bic_frame: paces one UART-style character (start..last stop) at an oversampled rate.
`default_nettype none

module bic_frame
    import bic_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
    input  logic       sr_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       enable,
    input  logic       abort,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       stop_bits,
    output logic       busy,
    output logic [3:0] bit_index,
    output logic       sample_strobe,
    output logic       char_complete
);

    bic_state_t state_q, state_d;
    logic [3:0] bit_q, bit_d;
    bic_cfg_t   cfg_q, cfg_d;

    logic     w_run;
    logic     w_tick_mid;
    logic     w_tick_wrap;
    logic     w_last_bit;
    bic_cfg_t w_cfg_in;

    assign w_run      = (state_q == RUN);
    assign w_last_bit = (bit_q == frame_len(cfg_q) - 4'd1);
    assign w_cfg_in   = {data_bits, parity_en, stop_bits};

    // Held at zero in IDLE so every frame starts from tick 0
    bic_tick_counter #(
        .OVERSAMPLE (OVERSAMPLE),
        .TICK_W     (TICK_W)
    ) u_tick (
        .sr_clk  (sr_clk),
        .reset_n (reset_n),
        .enable  (w_run & enable),
        .clear   (abort | ~w_run),
        .mid     (w_tick_mid),
        .wrap    (w_tick_wrap)
    );

    always_ff @(posedge sr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bit_q   <= 4'd0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cfg_d   = cfg_q;
        if (abort) begin
            state_d = IDLE;
            bit_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        bit_d   = 4'd0;
                        cfg_d   = w_cfg_in;
                    end
                end
                RUN: begin
                    if (w_tick_wrap) begin
                        if (!w_last_bit) begin
                            bit_d = bit_q + 4'd1;
                        end else if (start) begin
                            bit_d = 4'd0;
                            cfg_d = w_cfg_in;
                        end else begin
                            state_d = IDLE;
                            bit_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    bit_d   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        busy          = w_run;
        bit_index     = bit_q;
        sample_strobe = w_tick_mid;
        char_complete = w_tick_wrap & w_last_bit & ~abort;
    end

endmodule

`default_nettype wire
